// File: rtl/dma_copy_engine_if.sv
// Control and memory-port bundle for the block copy / fill DMA engine.
// master is the engine side, slave is the CPU/memory side.
interface dma_copy_engine_if #(
   parameter int CNT_W = 11
);
   logic             start;
   logic             mode;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [CNT_W-1:0] word_count;
   logic [31:0]      fill_value;
   logic             busy;
   logic             done;
   logic             error;
   logic             MemRead;
   logic             MemWrite;
   logic [31:0]      address;
   logic [31:0]      WriteData;
   logic [31:0]      ReadData;

   modport master (
      input  start, mode, src_addr, dst_addr,
      input  word_count, fill_value, ReadData,
      output busy, done, error,
      output MemRead, MemWrite, address, WriteData
   );

   modport slave (
      output start, mode, src_addr, dst_addr,
      output word_count, fill_value, ReadData,
      input  busy, done, error,
      input  MemRead, MemWrite, address, WriteData
   );
endinterface

// File: rtl/dma_copy_engine.sv
// Word-granular memcpy/memset DMA master for the data memory port.
// Copy alternates READ/WRITE per word; fill streams WRITE cycles.
module dma_copy_engine #(
   parameter int MEM_WORDS = 1024,
   parameter int CNT_W     = 11
) (
   input  logic clock,
   input  logic reset,
   dma_copy_engine_if.master bus
);
   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      FINISH
   } state_t;

   localparam logic [33:0] LIMIT = 34'(4 * MEM_WORDS);

   state_t           state;
   state_t           nextState;
   logic             modeQ;
   logic [31:0]      srcPtr;
   logic [31:0]      dstPtr;
   logic [31:0]      fillQ;
   logic [31:0]      dataBuf;
   logic [CNT_W-1:0] remaining;
   logic             errorQ;

   logic [33:0] span;
   logic [33:0] dstEnd;
   logic [33:0] srcEnd;
   logic        dstOk;
   logic        srcOk;
   logic        startOk;
   logic        zeroCount;
   logic        lastWord;

   // 34-bit sums so an address near 4 GiB cannot wrap past the check
   assign span = 34'(bus.word_count) << 2;
   assign dstEnd = {2'b00, bus.dst_addr} + span;
   assign srcEnd = {2'b00, bus.src_addr} + span;

   assign dstOk = (bus.dst_addr[1:0] == 2'b00)
               && (dstEnd <= LIMIT);
   assign srcOk = bus.mode
               || ((bus.src_addr[1:0] == 2'b00)
               && (srcEnd <= LIMIT));
   assign startOk   = dstOk && srcOk;
   assign zeroCount = (bus.word_count == '0);
   assign lastWord  = (remaining == CNT_W'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (bus.start && startOk) begin
               if (zeroCount) begin
                  nextState = FINISH;
               end else if (bus.mode) begin
                  nextState = WRITE;
               end else begin
                  nextState = READ;
               end
            end
         end
         READ: nextState = WRITE;
         WRITE: begin
            if (lastWord) begin
               nextState = FINISH;
            end else if (modeQ) begin
               nextState = WRITE;
            end else begin
               nextState = READ;
            end
         end
         FINISH: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         modeQ     <= 1'b0;
         srcPtr    <= '0;
         dstPtr    <= '0;
         fillQ     <= '0;
         dataBuf   <= '0;
         remaining <= '0;
         errorQ    <= 1'b0;
      end else begin
         errorQ <= (state == IDLE)
                && bus.start
                && !startOk;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  modeQ     <= bus.mode;
                  srcPtr    <= bus.src_addr;
                  dstPtr    <= bus.dst_addr;
                  fillQ     <= bus.fill_value;
                  remaining <= bus.word_count;
               end
            end
            READ: begin
               dataBuf <= bus.ReadData;
               srcPtr  <= srcPtr + 32'd4;
            end
            WRITE: begin
               dstPtr    <= dstPtr + 32'd4;
               remaining <= remaining - CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.address   = '0;
      bus.WriteData = '0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.error     = errorQ;
      unique case (state)
         READ: begin
            bus.MemRead = 1'b1;
            bus.address = srcPtr;
            bus.busy    = 1'b1;
         end
         WRITE: begin
            bus.MemWrite  = 1'b1;
            bus.address   = dstPtr;
            bus.WriteData = modeQ ? fillQ : dataBuf;
            bus.busy      = 1'b1;
         end
         FINISH: bus.done = 1'b1;
         default: begin
         end
      endcase
   end
endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a behavioural word memory.
// Bus activity is tallied at every negedge; tests compare deltas.
module tb_dma_copy_engine;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dma_copy_engine_if #(.CNT_W(11)) bus ();

   dma_copy_engine #(
      .MEM_WORDS(1024),
      .CNT_W(11)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   logic [31:0] mem [0:1023];
   logic        tbWe = 1'b0;
   logic [9:0]  tbIdx = '0;
   logic [31:0] tbData = '0;

   always @(posedge clock) begin
      if (tbWe) begin
         mem[tbIdx] <= tbData;
      end else if (bus.MemWrite && bus.address < 32'd4096) begin
         mem[bus.address[11:2]] <= bus.WriteData;
      end
   end

   assign bus.ReadData = (bus.MemRead && bus.address < 32'd4096)
                       ? mem[bus.address[11:2]] : 32'hBAD0BAD0;

   int cyc = 0;
   int nRd = 0;
   int nWr = 0;
   int nBoth = 0;
   int nWdBad = 0;
   int nAddrBad = 0;
   int nBusy = 0;
   int nDone = 0;
   int nErr = 0;
   int lastDone = -1;
   int lastErr = -1;
   logic [31:0] wrAddr [0:63];
   logic [31:0] wrData [0:63];

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (bus.MemRead) nRd <= nRd + 1;
      if (bus.MemWrite) begin
         wrAddr[nWr & 63] <= bus.address;
         wrData[nWr & 63] <= bus.WriteData;
         nWr <= nWr + 1;
      end
      if (bus.MemRead && bus.MemWrite) nBoth <= nBoth + 1;
      if (!bus.MemWrite && bus.WriteData !== 32'd0) nWdBad <= nWdBad + 1;
      if (!bus.MemRead && !bus.MemWrite && bus.address !== 32'd0)
         nAddrBad <= nAddrBad + 1;
      if (bus.busy) nBusy <= nBusy + 1;
      if (bus.done) begin
         nDone <= nDone + 1;
         lastDone <= cyc + 1;
      end
      if (bus.error) begin
         nErr <= nErr + 1;
         lastErr <= cyc + 1;
      end
   end

   int passed = 0;
   int total = 0;
   int startCyc, bRd, bWr, bBusy, bDone, bErr;

   task automatic snap();
      bRd = nRd;
      bWr = nWr;
      bBusy = nBusy;
      bDone = nDone;
      bErr = nErr;
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clock);
      #1;
      tbWe = 1'b1;
      tbIdx = 10'(idx);
      tbData = val;
      @(posedge clock);
      #1;
      tbWe = 1'b0;
   endtask

   task automatic launch(input logic m, input logic [31:0] src,
                         input logic [31:0] dst, input int cnt,
                         input logic [31:0] fill);
      @(negedge clock);
      #1;
      snap();
      startCyc = cyc;
      bus.mode = m;
      bus.src_addr = src;
      bus.dst_addr = dst;
      bus.word_count = 11'(cnt);
      bus.fill_value = fill;
      bus.start = 1'b1;
      @(negedge clock);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({bus.busy, bus.done, bus.error} !== 3'b000)
         $display("FAIL reset_status got %b want 000",
                  {bus.busy, bus.done, bus.error});
      else passed++;
      total++;
      if ({bus.MemRead, bus.MemWrite} !== 2'b00)
         $display("FAIL reset_strobes got %b want 00",
                  {bus.MemRead, bus.MemWrite});
      else passed++;
      total++;
      if (bus.address !== 32'd0 || bus.WriteData !== 32'd0)
         $display("FAIL reset_bus got %h/%h want 0/0",
                  bus.address, bus.WriteData);
      else passed++;
      @(negedge clock);
      #1;
      reset = 1'b0;
      idle(2);
      total++;
      if (nBusy + nRd + nWr + nDone + nErr !== 0)
         $display("FAIL idle_quiet got %0d events want 0",
                  nBusy + nRd + nWr + nDone + nErr);
      else passed++;
   endtask

   task automatic test_copy();
      poke(0, 32'h11);
      poke(1, 32'h22);
      poke(2, 32'h33);
      poke(3, 32'h44);
      launch(1'b0, 32'h000, 32'h100, 4, 32'h0);
      idle(12);
      total++;
      if (lastDone - startCyc !== 9)
         $display("FAIL copy_latency got %0d want 9", lastDone - startCyc);
      else passed++;
      total++;
      if (nDone - bDone !== 1)
         $display("FAIL copy_done_count got %0d want 1", nDone - bDone);
      else passed++;
      total++;
      if (nBusy - bBusy !== 8)
         $display("FAIL copy_busy got %0d want 8", nBusy - bBusy);
      else passed++;
      total++;
      if (nRd - bRd !== 4 || nWr - bWr !== 4)
         $display("FAIL copy_strobes got %0d/%0d want 4/4",
                  nRd - bRd, nWr - bWr);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wrAddr[(bWr + i) & 63] !== 32'h100 + 32'(4 * i))
            $display("FAIL copy_waddr%0d got %h want %h", i,
                     wrAddr[(bWr + i) & 63], 32'h100 + 32'(4 * i));
         else passed++;
         total++;
         if (mem[16'h40 + i] !== 32'(32'h11 * (i + 1)))
            $display("FAIL copy_mem%0d got %h want %h", i,
                     mem[16'h40 + i], 32'(32'h11 * (i + 1)));
         else passed++;
      end
   endtask

   task automatic test_fill();
      launch(1'b1, 32'h0, 32'h200, 3, 32'hDEADBEEF);
      idle(6);
      total++;
      if (lastDone - startCyc !== 4)
         $display("FAIL fill_latency got %0d want 4", lastDone - startCyc);
      else passed++;
      total++;
      if (nRd - bRd !== 0 || nWr - bWr !== 3)
         $display("FAIL fill_strobes got %0d/%0d want 0/3",
                  nRd - bRd, nWr - bWr);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (wrAddr[(bWr + i) & 63] !== 32'h200 + 32'(4 * i)
             || wrData[(bWr + i) & 63] !== 32'hDEADBEEF)
            $display("FAIL fill_write%0d got %h:%h want %h:deadbeef", i,
                     wrAddr[(bWr + i) & 63], wrData[(bWr + i) & 63],
                     32'h200 + 32'(4 * i));
         else passed++;
         total++;
         if (mem[16'h80 + i] !== 32'hDEADBEEF)
            $display("FAIL fill_mem%0d got %h want deadbeef", i,
                     mem[16'h80 + i]);
         else passed++;
      end
   endtask

   task automatic test_zero_count();
      launch(1'b1, 32'h0, 32'h300, 0, 32'h1);
      idle(3);
      total++;
      if (lastDone - startCyc !== 1 || nDone - bDone !== 1)
         $display("FAIL zero_done got lat %0d cnt %0d want 1/1",
                  lastDone - startCyc, nDone - bDone);
      else passed++;
      total++;
      if (nBusy - bBusy + nRd - bRd + nWr - bWr + nErr - bErr !== 0)
         $display("FAIL zero_quiet got %0d events want 0",
                  nBusy - bBusy + nRd - bRd + nWr - bWr + nErr - bErr);
      else passed++;
   endtask

   task automatic test_rejects();
      logic [31:0] dsts [0:3];
      logic [31:0] srcs [0:3];
      int cnts [0:3];
      logic modes [0:3];
      dsts = '{32'h102, 32'hFFC, 32'h100, 32'h000};
      srcs = '{32'h000, 32'h000, 32'h001, 32'hFF8};
      cnts = '{1, 2, 1, 3};
      modes = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         launch(modes[i], srcs[i], dsts[i], cnts[i], 32'h5);
         idle(4);
         total++;
         if (nErr - bErr !== 1 || lastErr - startCyc !== 1)
            $display("FAIL reject%0d_error got cnt %0d lat %0d want 1/1",
                     i, nErr - bErr, lastErr - startCyc);
         else passed++;
         total++;
         if (nDone - bDone + nBusy - bBusy + nRd - bRd + nWr - bWr !== 0)
            $display("FAIL reject%0d_quiet got %0d events want 0", i,
                     nDone - bDone + nBusy - bBusy + nRd - bRd + nWr - bWr);
         else passed++;
      end
      launch(1'b1, 32'h0, 32'hFFC, 1, 32'hCAFE);
      idle(4);
      total++;
      if (nErr - bErr !== 0 || lastDone - startCyc !== 2)
         $display("FAIL top_word_accept got err %0d lat %0d want 0/2",
                  nErr - bErr, lastDone - startCyc);
      else passed++;
      total++;
      if (mem[1023] !== 32'hCAFE)
         $display("FAIL top_word_mem got %h want 0000cafe", mem[1023]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      poke(16'h60, 32'h5A5A);
      launch(1'b0, 32'h000, 32'h140, 4, 32'h0);
      bus.mode = 1'b1;
      bus.src_addr = 32'h10;
      bus.dst_addr = 32'h180;
      bus.word_count = 11'd2;
      bus.fill_value = 32'h99;
      bus.start = 1'b1;
      @(negedge clock);
      #1;
      bus.start = 1'b0;
      idle(10);
      total++;
      if (lastDone - startCyc !== 9 || nDone - bDone !== 1)
         $display("FAIL busy_start_done got lat %0d cnt %0d want 9/1",
                  lastDone - startCyc, nDone - bDone);
      else passed++;
      total++;
      if (nErr - bErr !== 0 || nWr - bWr !== 4)
         $display("FAIL busy_start_side got err %0d wr %0d want 0/4",
                  nErr - bErr, nWr - bWr);
      else passed++;
      total++;
      if (mem[16'h50] !== 32'h11 || mem[16'h53] !== 32'h44
          || mem[16'h60] !== 32'h5A5A)
         $display("FAIL busy_start_mem got %h %h %h want 11 44 5a5a",
                  mem[16'h50], mem[16'h53], mem[16'h60]);
      else passed++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) poke(16'h70 + i, 32'hEEEEEEEE);
      launch(1'b0, 32'h000, 32'h1C0, 4, 32'h0);
      idle(5);
      total++;
      if (!bus.MemWrite || bus.address !== 32'h1C8)
         $display("FAIL midreset_phase got we %b addr %h want 1 1c8",
                  bus.MemWrite, bus.address);
      else passed++;
      reset = 1'b1;
      #1;
      total++;
      if ({bus.busy, bus.done, bus.error, bus.MemRead, bus.MemWrite} !== 5'b0
          || bus.address !== 32'd0 || bus.WriteData !== 32'd0)
         $display("FAIL midreset_outputs got %b %h %h want 0 0 0",
                  {bus.busy, bus.done, bus.error, bus.MemRead, bus.MemWrite},
                  bus.address, bus.WriteData);
      else passed++;
      idle(1);
      reset = 1'b0;
      snap();
      idle(3);
      total++;
      if (nRd - bRd + nWr - bWr + nDone - bDone + nBusy - bBusy !== 0)
         $display("FAIL midreset_quiet got %0d events want 0",
                  nRd - bRd + nWr - bWr + nDone - bDone + nBusy - bBusy);
      else passed++;
      total++;
      if (mem[16'h70] !== 32'h11 || mem[16'h71] !== 32'h22
          || mem[16'h72] !== 32'hEEEEEEEE || mem[16'h73] !== 32'hEEEEEEEE)
         $display("FAIL midreset_mem got %h %h %h %h want 11 22 eeeeeeee x2",
                  mem[16'h70], mem[16'h71], mem[16'h72], mem[16'h73]);
      else passed++;
      launch(1'b1, 32'h0, 32'h1C8, 2, 32'h77);
      idle(4);
      total++;
      if (lastDone - startCyc !== 3 || mem[16'h72] !== 32'h77
          || mem[16'h73] !== 32'h77)
         $display("FAIL postreset_fill got lat %0d mem %h %h want 3 77 77",
                  lastDone - startCyc, mem[16'h72], mem[16'h73]);
      else passed++;
   endtask

   task automatic test_overlap();
      poke(0, 32'd1);
      poke(1, 32'd2);
      poke(2, 32'd3);
      poke(3, 32'd4);
      launch(1'b0, 32'h0, 32'h4, 3, 32'h0);
      idle(9);
      total++;
      if (lastDone - startCyc !== 7 || nErr - bErr !== 0)
         $display("FAIL overlap_done got lat %0d err %0d want 7/0",
                  lastDone - startCyc, nErr - bErr);
      else passed++;
      total++;
      if (mem[0] !== 32'd1 || mem[1] !== 32'd1 || mem[2] !== 32'd1
          || mem[3] !== 32'd1)
         $display("FAIL overlap_mem got %0d %0d %0d %0d want 1 1 1 1",
                  mem[0], mem[1], mem[2], mem[3]);
      else passed++;
   endtask

   task automatic test_strobe_rules();
      total++;
      if (nBoth !== 0)
         $display("FAIL both_strobes got %0d want 0", nBoth);
      else passed++;
      total++;
      if (nWdBad !== 0 || nAddrBad !== 0)
         $display("FAIL idle_bus_nonzero got wd %0d addr %0d want 0/0",
                  nWdBad, nAddrBad);
      else passed++;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.mode = 1'b0;
      bus.src_addr = '0;
      bus.dst_addr = '0;
      bus.word_count = '0;
      bus.fill_value = '0;
      test_reset();
      test_copy();
      test_fill();
      test_zero_count();
      test_rejects();
      test_back_to_back();
      test_reset_mid();
      test_overlap();
      test_strobe_rules();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
